// File: rtl/alu_adder_hold_pkg.sv
// Shared definitions for the ALU adder hold register: the op-select encoding and its
// priority, the BCD correction constants and the default datapath width.
package alu_adder_hold_pkg;

    localparam int WIDTH_DEFAULT = 8;

    localparam logic [7:0] BCD_LOW_ADJ    = 8'h06;
    localparam logic [7:0] BCD_HIGH_ADJ   = 8'h60;
    localparam logic [4:0] BCD_NIBBLE_MAX = 5'd9;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_SUM  = 3'd1,
        OP_AND  = 3'd2,
        OP_EOR  = 3'd3,
        OP_OR   = 3'd4,
        OP_SRS  = 3'd5
    } op_sel_e;

    // Several select lines may be high at once; the first one in this order wins.
    function automatic op_sel_e op_select(input logic sums, input logic ands,
                                          input logic eors, input logic ors,
                                          input logic srs);
        if (sums)      return OP_SUM;
        else if (ands) return OP_AND;
        else if (eors) return OP_EOR;
        else if (ors)  return OP_OR;
        else if (srs)  return OP_SRS;
        else           return OP_NONE;
    endfunction

endpackage

// File: rtl/alu_decimal_adjust.sv
// Combinational BCD correction of a latched 8-bit binary sum, using its binary carry and
// half-carry. Subtraction assumes the B operand arrived already inverted.
module alu_decimal_adjust
    import alu_adder_hold_pkg::*;
(
    input  logic [7:0] sum_in,
    input  logic       carry_in,
    input  logic       half_carry_in,
    input  logic       dec_sub,
    output logic [7:0] dec_out,
    output logic       dec_carry
);

    logic       low_adj;
    logic       high_adj;
    logic [8:0] t_lo;
    logic [8:0] t_hi;
    logic [7:0] sub_lo;

    always_comb begin
        low_adj   = 1'b0;
        high_adj  = 1'b0;
        t_lo      = {1'b0, sum_in};
        t_hi      = {1'b0, sum_in};
        sub_lo    = sum_in;
        dec_out   = sum_in;
        dec_carry = carry_in;
        if (dec_sub) begin
            // A missing carry means a borrow out of that digit; take back the 6 it skipped.
            sub_lo    = half_carry_in ? sum_in : sum_in - BCD_LOW_ADJ;
            dec_out   = carry_in ? sub_lo : sub_lo - BCD_HIGH_ADJ;
            dec_carry = carry_in;
        end else begin
            low_adj   = half_carry_in || (sum_in[3:0] > BCD_NIBBLE_MAX[3:0]);
            t_lo      = low_adj ? ({1'b0, sum_in} + {1'b0, BCD_LOW_ADJ}) : {1'b0, sum_in};
            high_adj  = carry_in || (t_lo[8:4] > BCD_NIBBLE_MAX);
            t_hi      = high_adj ? (t_lo + {1'b0, BCD_HIGH_ADJ}) : t_lo;
            dec_out   = t_hi[7:0];
            dec_carry = carry_in || high_adj;
        end
    end

endmodule

// File: rtl/alu_adder_hold.sv
// Adder hold register: stage 1 latches the selected op with carry/overflow/half-carry;
// stage 2 (built only with ALU_DECIMAL_EN) latches the BCD-corrected result.
module alu_adder_hold
    import alu_adder_hold_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_load,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    input  logic             op_sums,
    input  logic             op_ands,
    input  logic             op_eors,
    input  logic             op_ors,
    input  logic             op_srs,
    input  logic             dec_en,
    input  logic             dec_sub,
    output logic [WIDTH-1:0] add_out,
    output logic             carry_out,
    output logic             overflow_out,
    output logic             half_carry_out,
    output logic             add_valid,
    output logic [WIDTH-1:0] dec_out,
    output logic             dec_carry_out,
    output logic             dec_valid
);

    // Handshake: alu_load is valid-only with no ready/backpressure; an op is taken on every
    // clock where alu_load=1 and a select is set, and each valid output pulses once per op.
    op_sel_e          op_sel;
    logic             accept;
    logic [WIDTH:0]   sum_full;
    logic [4:0]       nib_sum;

    logic [WIDTH-1:0] add_d, add_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             hc_d, hc_q;
    logic             valid_d, valid_q;
    logic             dec_en_d, dec_en_q;
    logic             dec_sub_d, dec_sub_q;
    logic             was_sum_d, was_sum_q;

    always_comb begin
        op_sel    = op_select(op_sums, op_ands, op_eors, op_ors, op_srs);
        accept    = alu_load && (op_sel != OP_NONE);
        sum_full  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, carry_in};
        nib_sum   = {1'b0, a_in[3:0]} + {1'b0, b_in[3:0]} + {4'b0, carry_in};
        add_d     = add_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        hc_d      = hc_q;
        valid_d   = accept;
        dec_en_d  = dec_en_q;
        dec_sub_d = dec_sub_q;
        was_sum_d = was_sum_q;
        if (accept) begin
            carry_d   = 1'b0;
            ovf_d     = 1'b0;
            hc_d      = 1'b0;
            dec_en_d  = dec_en;
            dec_sub_d = dec_sub;
            was_sum_d = (op_sel == OP_SUM);
            case (op_sel)
                OP_SUM: begin
                    add_d   = sum_full[WIDTH-1:0];
                    carry_d = sum_full[WIDTH];
                    hc_d    = nib_sum[4];
                    ovf_d   = ~(a_in[WIDTH-1] ^ b_in[WIDTH-1]) & (a_in[WIDTH-1] ^ sum_full[WIDTH-1]);
                end
                OP_AND:  add_d = a_in & b_in;
                OP_EOR:  add_d = a_in ^ b_in;
                OP_OR:   add_d = a_in | b_in;
                OP_SRS: begin
                    add_d   = {carry_in, a_in[WIDTH-1:1]};
                    carry_d = a_in[0];
                end
                default: add_d = add_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_q     <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            hc_q      <= 1'b0;
            valid_q   <= 1'b0;
            dec_en_q  <= 1'b0;
            dec_sub_q <= 1'b0;
            was_sum_q <= 1'b0;
        end else begin
            add_q     <= add_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            hc_q      <= hc_d;
            valid_q   <= valid_d;
            dec_en_q  <= dec_en_d;
            dec_sub_q <= dec_sub_d;
            was_sum_q <= was_sum_d;
        end
    end

    assign add_out        = add_q;
    assign carry_out      = carry_q;
    assign overflow_out   = ovf_q;
    assign half_carry_out = hc_q;
    assign add_valid      = valid_q;

`ifdef ALU_DECIMAL_EN
    logic [WIDTH-1:0] adj_out;
    logic             adj_carry;
    logic [WIDTH-1:0] dec_d, dec_q;
    logic             dec_carry_d, dec_carry_q;
    logic             dec_valid_d, dec_valid_q;

    generate
        if (WIDTH == 8) begin : g_adjust
            alu_decimal_adjust u_adjust (
                .sum_in        (add_q),
                .carry_in      (carry_q),
                .half_carry_in (hc_q),
                .dec_sub       (dec_sub_q),
                .dec_out       (adj_out),
                .dec_carry     (adj_carry)
            );
        end else begin : g_no_adjust
            logic unused_dec_sub;
            assign unused_dec_sub = dec_sub_q;
            assign adj_out        = add_q;
            assign adj_carry      = carry_q;
        end
    endgenerate

    always_comb begin
        dec_d       = dec_q;
        dec_carry_d = dec_carry_q;
        dec_valid_d = valid_q;
        if (valid_q) begin
            dec_d       = (was_sum_q && dec_en_q) ? adj_out : add_q;
            dec_carry_d = (was_sum_q && dec_en_q) ? adj_carry : carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q       <= '0;
            dec_carry_q <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            dec_q       <= dec_d;
            dec_carry_q <= dec_carry_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_out       = dec_q;
    assign dec_carry_out = dec_carry_q;
    assign dec_valid     = dec_valid_q;
`else
    // Decimal mode is not built: stage-1 decimal tags are dead and synthesis prunes them.
    logic unused_dec_tags;
    assign unused_dec_tags = ^{dec_en_q, dec_sub_q, was_sum_q};

    assign dec_out       = add_q;
    assign dec_carry_out = carry_q;
    assign dec_valid     = valid_q;
`endif

endmodule

// File: tb/tb_alu_adder_hold.sv
// Directed, table-driven bench for alu_adder_hold; adapts its decimal-path expectations to
// whether ALU_DECIMAL_EN is defined.
module tb_alu_adder_hold;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_load;
    logic [7:0] a_in, b_in;
    logic       carry_in;
    logic       op_sums, op_ands, op_eors, op_ors, op_srs;
    logic       dec_en, dec_sub;
    logic [7:0] add_out;
    logic       carry_out, overflow_out, half_carry_out, add_valid;
    logic [7:0] dec_out;
    logic       dec_carry_out, dec_valid;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [4:0] ops;   // {sums, ands, eors, ors, srs}
        logic       de;
        logic       ds;
        logic [7:0] exp_add;
        logic       exp_c;
        logic       exp_v;
        logic       exp_h;
        logic [7:0] exp_dec;
        logic       exp_dc;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    alu_adder_hold #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_load       (alu_load),
        .a_in           (a_in),
        .b_in           (b_in),
        .carry_in       (carry_in),
        .op_sums        (op_sums),
        .op_ands        (op_ands),
        .op_eors        (op_eors),
        .op_ors         (op_ors),
        .op_srs         (op_srs),
        .dec_en         (dec_en),
        .dec_sub        (dec_sub),
        .add_out        (add_out),
        .carry_out      (carry_out),
        .overflow_out   (overflow_out),
        .half_carry_out (half_carry_out),
        .add_valid      (add_valid),
        .dec_out        (dec_out),
        .dec_carry_out  (dec_carry_out),
        .dec_valid      (dec_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic [4:0] ops, input logic de, input logic ds,
                                input logic [7:0] ea, input logic ec, input logic ev,
                                input logic eh, input logic [7:0] ed, input logic edc);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.ops = ops; v.de = de; v.ds = ds;
        v.exp_add = ea; v.exp_c = ec; v.exp_v = ev; v.exp_h = eh;
        v.exp_dec = ed; v.exp_dc = edc;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        alu_load = 1'b1;
        a_in     = v.a;
        b_in     = v.b;
        carry_in = v.cin;
        {op_sums, op_ands, op_eors, op_ors, op_srs} = v.ops;
        dec_en   = v.de;
        dec_sub  = v.ds;
    endtask

    task automatic drive_idle(input logic load);
        alu_load = load;
        {op_sums, op_ands, op_eors, op_ors, op_srs} = 5'b0;
        a_in = 8'h5A; b_in = 8'hA5; carry_in = 1'b1;
        dec_en = 1'b0; dec_sub = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stage1(input string tag, input vec_t v);
        check({tag, " add_out"},    add_out,        v.exp_add);
        check({tag, " carry"},      {7'b0, carry_out},      {7'b0, v.exp_c});
        check({tag, " overflow"},   {7'b0, overflow_out},   {7'b0, v.exp_v});
        check({tag, " half_carry"}, {7'b0, half_carry_out}, {7'b0, v.exp_h});
        check({tag, " add_valid"},  {7'b0, add_valid},      8'd1);
    endtask

    task automatic check_dec(input string tag, input vec_t v, input logic use_dec);
        check({tag, " dec_out"},   dec_out, use_dec ? v.exp_dec : v.exp_add);
        check({tag, " dec_carry"}, {7'b0, dec_carry_out}, {7'b0, use_dec ? v.exp_dc : v.exp_c});
        check({tag, " dec_valid"}, {7'b0, dec_valid}, 8'd1);
    endtask

    initial begin
        //                a      b      cin ops       de    ds    add    c     v     h     dec    dc
        vecs[0]  = mk(8'h50, 8'h50, 0, 5'b10000, 0, 0, 8'hA0, 0, 1, 0, 8'hA0, 0);
        vecs[1]  = mk(8'h19, 8'h28, 0, 5'b10000, 1, 0, 8'h41, 0, 0, 1, 8'h47, 0);
        vecs[2]  = mk(8'h99, 8'h01, 0, 5'b10000, 1, 0, 8'h9A, 0, 0, 0, 8'h00, 1);
        vecs[3]  = mk(8'h42, 8'hEC, 1, 5'b10000, 1, 1, 8'h2F, 1, 0, 0, 8'h29, 1);
        vecs[4]  = mk(8'h81, 8'h00, 1, 5'b00001, 0, 0, 8'hC0, 1, 0, 0, 8'hC0, 1);
        vecs[5]  = mk(8'hF0, 8'h3C, 0, 5'b01010, 0, 0, 8'h30, 0, 0, 0, 8'h30, 0);
        vecs[6]  = mk(8'hF0, 8'h3C, 1, 5'b00111, 0, 0, 8'hCC, 0, 0, 0, 8'hCC, 0);
        vecs[7]  = mk(8'hF0, 8'h0F, 1, 5'b00010, 0, 0, 8'hFF, 0, 0, 0, 8'hFF, 0);
        vecs[8]  = mk(8'hFF, 8'h01, 0, 5'b10000, 0, 0, 8'h00, 1, 0, 1, 8'h00, 1);
        vecs[9]  = mk(8'h7F, 8'h01, 0, 5'b10000, 0, 0, 8'h80, 0, 1, 1, 8'h80, 0);
        vecs[10] = mk(8'h99, 8'h0F, 0, 5'b01000, 1, 0, 8'h09, 0, 0, 0, 8'h09, 0);
        vecs[11] = mk(8'h50, 8'hDA, 1, 5'b10000, 1, 1, 8'h2B, 1, 0, 0, 8'h25, 1);
        vecs[12] = mk(8'h10, 8'hDF, 1, 5'b10000, 1, 1, 8'hF0, 0, 0, 1, 8'h90, 0);
        vecs[13] = mk(8'h0F, 8'h0F, 0, 5'b10000, 1, 0, 8'h1E, 0, 0, 1, 8'h24, 0);
        vecs[14] = mk(8'h02, 8'h00, 0, 5'b00001, 1, 1, 8'h01, 0, 0, 0, 8'h01, 0);

        rst_n = 1'b0;
        drive_idle(1'b0);
        tick();
        tick();
        check("reset add_out",    add_out, 8'h00);
        check("reset flags",      {4'b0, carry_out, overflow_out, half_carry_out, add_valid}, 8'h00);
        check("reset dec_out",    dec_out, 8'h00);
        check("reset dec_flags",  {6'b0, dec_carry_out, dec_valid}, 8'h00);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream: each cycle checks stage 1 of op i and stage 2 of op i-1.
        for (int i = 0; i < NV; i++) begin
            drive_op(vecs[i]);
            tick();
            check_stage1($sformatf("vec%0d", i), vecs[i]);
`ifdef ALU_DECIMAL_EN
            if (i > 0) check_dec($sformatf("vec%0d", i - 1), vecs[i - 1], 1'b1);
`else
            check_dec($sformatf("vec%0d", i), vecs[i], 1'b0);
`endif
        end

        // Idle: add_valid drops after one pulse per op, results hold.
        drive_idle(1'b0);
        tick();
        check("idle add_valid", {7'b0, add_valid}, 8'd0);
        check("idle add_out",   add_out, vecs[NV-1].exp_add);
`ifdef ALU_DECIMAL_EN
        check_dec("last", vecs[NV-1], 1'b1);
        tick();
        check("idle2 dec_valid", {7'b0, dec_valid}, 8'd0);
        check("idle2 dec_out",   dec_out, vecs[NV-1].exp_dec);
`else
        check("idle dec_valid", {7'b0, dec_valid}, 8'd0);
        check("idle dec_out",   dec_out, vecs[NV-1].exp_add);
`endif

        // alu_load with no select: nothing latched.
        drive_op(vecs[0]);
        tick();
        drive_idle(1'b1);
        tick();
        check("noop add_valid", {7'b0, add_valid}, 8'd0);
        check("noop add_out",   add_out, vecs[0].exp_add);
        check("noop overflow",  {7'b0, overflow_out}, 8'd1);
        tick();
        check("noop2 add_out",  add_out, vecs[0].exp_add);
        check("noop2 dec_valid", {7'b0, dec_valid}, 8'd0);

        // Reset right after a decimal op is accepted discards it.
        drive_op(vecs[2]);
        tick();
        check("prereset add_out", add_out, vecs[2].exp_add);
        rst_n = 1'b0;
        drive_idle(1'b0);
        tick();
        check("midreset add_out",   add_out, 8'h00);
        check("midreset flags",     {4'b0, carry_out, overflow_out, half_carry_out, add_valid}, 8'h00);
        check("midreset dec_out",   dec_out, 8'h00);
        check("midreset dec_flags", {6'b0, dec_carry_out, dec_valid}, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("postreset%0d dec_valid", k), {7'b0, dec_valid}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_adder_hold.md
Name: alu_adder_hold

Overview:
- Consumer of the A-side and B-side ALU input registers.
- Performs the selected 8-bit operation, latches it into the adder hold register (ADD) with carry (ACR), overflow (AVR) and half-carry.
- Optionally runs a second decimal-correction stage for BCD ADC/SBC.
- Fully pipelined; accepts one operation per cycle.

Parameters:
- WIDTH, 8, datapath width. Decimal correction is defined only for 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- alu_load  input  1  operation valid this cycle
- a_in  input  8  A-side operand
- b_in  input  8  B-side operand from b_input_register (already inverted for subtraction)
- carry_in  input  1  carry into bit 0, or bit 7 fill for SRS
- op_sums  input  1  add
- op_ands  input  1  AND
- op_eors  input  1  XOR
- op_ors  input  1  OR
- op_srs  input  1  shift right
- dec_en  input  1  decimal mode for this op
- dec_sub  input  1  decimal op is a subtraction
- add_out  output  8  adder hold register
- carry_out  output  1  ACR, binary
- overflow_out  output  1  AVR
- half_carry_out  output  1  carry out of bit 3
- add_valid  output  1  add_out updated this cycle
- dec_out  output  8  decimal-corrected result
- dec_carry_out  output  1  decimal-corrected carry
- dec_valid  output  1  dec_out updated this cycle

Behaviour:
- Reset: all outputs 0 and both valid bits 0. A reset cycle discards any in-flight ops.
- Op select priority: sums > ands > eors > ors > srs.
- alu_load with no op select: no register update and add_valid stays 0.
- Stage 1 (latency 1) registers update only when alu_load=1 and an op is selected. Otherwise they hold.
  - sums: s = a_in + b_in + carry_in (9 bits). add_out = s[7:0]; carry_out = s[8].
  - sums: half_carry_out = carry out of a_in[3:0] + b_in[3:0] + carry_in.
  - sums: overflow_out = (~(a_in^b_in) & (a_in^s))[7].
  - ands / eors / ors: add_out = bitwise result. carry_out, overflow_out and half_carry_out are cleared.
  - srs: add_out = {carry_in, a_in[7:1]}; carry_out = a_in[0]; overflow_out = 0; half_carry_out = 0.
- add_valid is high exactly one cycle after each accepted op and pulses once per op. Back-to-back ops give a continuously high add_valid.
- Stage 1 latches dec_en and dec_sub, and a "was sums" flag, alongside the data.
- Stage 2 (latency 2): dec_valid follows add_valid by one cycle.
  - Correction applies only if the stage-1 op was sums and dec_en=1. Otherwise dec_out = add_out and dec_carry_out = carry_out.
  - Add correction:
    - Low adjust if half_carry or add_out[3:0] > 9: t = add_out + 0x06 (9-bit).
    - High adjust if carry or t[8:4] > 9: t = t + 0x60.
    - dec_carry_out = carry | high adjust.
    - dec_out = t[7:0].
  - Sub correction:
    - Subtract 0x06 if !half_carry.
    - Subtract 0x60 if !carry.
    - dec_carry_out = carry.
    - All arithmetic is modulo 256.
- Overflow in decimal mode is the binary AVR; no correction is applied.
- Operands are not range-checked. Invalid BCD inputs give the deterministic result of the rules above.

Optional Feature:
- ALU_DECIMAL_EN defined: stage 2 is present as described.
- ALU_DECIMAL_EN undefined:
  - dec_en and dec_sub are ignored.
  - dec_out, dec_carry_out and dec_valid are combinational copies of add_out, carry_out and add_valid (latency 1).
  - No stage-2 flops are built.

Decomposition:
- Shared package holds:
  - the op-select encoding constants and priority order;
  - BCD constants (0x06, 0x60, the nibble limit 9);
  - WIDTH default.
- One natural sub-module, alu_decimal_adjust: combinational correction for stage 2, instantiated only under ALU_DECIMAL_EN.

Test Plan:
- Binary add: a=0x50, b=0x50, cin=0, sums -> next cycle add_out=0xA0, carry=0, overflow=1, add_valid=1 for one cycle.
- Decimal add: a=0x19, b=0x28, cin=0, sums, dec_en -> after 2 cycles dec_out=0x47, dec_carry=0. A second op, a=0x99, b=0x01 back-to-back -> next cycle dec_out=0x00, dec_carry=1.
- Decimal sub: a=0x42, b=0xEC (inverted 0x13), cin=1, sums, dec_en, dec_sub -> add_out=0x2F, carry=1, half_carry=0; then dec_out=0x29, dec_carry=1.
- Shift and logic: a=0x81, cin=1, srs -> add_out=0xC0, carry=1. Next cycle ands+ors, a=0xF0, b=0x3C -> add_out=0x30 (AND wins), carry=0.
- No-op hold: alu_load=1 with no select, or alu_load=0 -> add_out unchanged, add_valid=0.
- Reset mid-op: load 0x99+0x01 decimal, assert rst_n=0 next cycle -> all outputs 0, dec_valid never pulses for that op.
- Build without ALU_DECIMAL_EN: 0x19+0x28 with dec_en -> dec_out=0x41 in same cycle as add_valid.
